// File: rtl/tdc_readout_arbiter_pkg.sv
// Shared types and helpers for the TDC readout arbiter: FSM states, default sizes
// and the round-robin search used by the picker.
package TDCArbPackage;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_SEND = 1'b1
  } arb_states;

  localparam int DEFAULT_CHANNEL_COUNT  = 2;
  localparam int DEFAULT_DATA_WIDTH     = 16;
  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  // Upper bound on channels the search helper can handle.
  localparam int RR_MAX_CHANNELS = 64;
  localparam int RR_IDX_W        = 6;

  // First set bit of mask searching upward from last+1, wrapping modulo count.
  // Returns -1 when no bit in mask[count-1:0] is set. Walking downward lets the
  // nearest candidate overwrite the farther ones without an early exit.
  function automatic int rr_next_index(input logic [RR_MAX_CHANNELS-1:0] mask,
                                       input int last,
                                       input int count);
    int cand;
    rr_next_index = -1;
    for (int k = RR_MAX_CHANNELS; k >= 1; k--) begin
      if (k <= count) begin
        cand = (last + k) % count;
        if (mask[cand[RR_IDX_W-1:0]]) begin
          rr_next_index = cand;
        end
      end
    end
  endfunction

endpackage

// File: rtl/tdc_readout_arbiter_if.sv
// Channel-side and readout-side signals of the TDC readout arbiter.
// master: the arbiter; slave: the capture logic, enable controller and readout FIFO.
interface tdc_readout_arbiter_if
  import TDCArbPackage::*;
#(
  parameter int CHANNEL_COUNT = DEFAULT_CHANNEL_COUNT,
  parameter int DATA_WIDTH    = DEFAULT_DATA_WIDTH
);
  localparam int ID_WIDTH = $clog2(CHANNEL_COUNT);

  logic [CHANNEL_COUNT-1:0]            enable_channels;
  logic [CHANNEL_COUNT-1:0]            ch_valid;
  logic [CHANNEL_COUNT*DATA_WIDTH-1:0] ch_data;
  logic [CHANNEL_COUNT-1:0]            ch_ack;
  logic                                out_valid;
  logic                                out_ready;
  logic [DATA_WIDTH-1:0]               out_data;
  logic [ID_WIDTH-1:0]                 out_channel;
  logic                                busy;
  logic                                timeout_err;

  modport master (
    input  enable_channels,
    input  ch_valid,
    input  ch_data,
    input  out_ready,
    output ch_ack,
    output out_valid,
    output out_data,
    output out_channel,
    output busy,
    output timeout_err
  );

  modport slave (
    output enable_channels,
    output ch_valid,
    output ch_data,
    output out_ready,
    input  ch_ack,
    input  out_valid,
    input  out_data,
    input  out_channel,
    input  busy,
    input  timeout_err
  );

endinterface

// File: rtl/tdc_readout_arbiter_rr_picker.sv
// Combinational round-robin picker: first eligible channel after last_grant.
module tdc_rr_picker
  import TDCArbPackage::*;
#(
  parameter int CHANNEL_COUNT = DEFAULT_CHANNEL_COUNT,
  parameter int ID_WIDTH      = $clog2(CHANNEL_COUNT)
) (
  input  logic [CHANNEL_COUNT-1:0] eligible,
  input  logic [ID_WIDTH-1:0]      last_grant,
  output logic                     found,
  output logic [ID_WIDTH-1:0]      idx
);

  logic [RR_MAX_CHANNELS-1:0] mask_ext;
  int                         pick;

  always_comb begin
    mask_ext                      = '0;
    mask_ext[CHANNEL_COUNT-1:0]   = eligible;
    pick                          = rr_next_index(mask_ext, int'(last_grant), CHANNEL_COUNT);
    found                         = (pick >= 0);
    idx                           = found ? pick[ID_WIDTH-1:0] : '0;
  end

endmodule

// File: rtl/tdc_readout_arbiter.sv
// Round-robin arbiter sharing one readout stream between TDC channels.
// Define TDCARB_TIMEOUT_EN to drop words stalled in SEND for TIMEOUT_CYCLES cycles.
module tdc_readout_arbiter
  import TDCArbPackage::*;
#(
  parameter int CHANNEL_COUNT  = DEFAULT_CHANNEL_COUNT,
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input logic                  clk,
  input logic                  reset_n,
  tdc_readout_arbiter_if.master bus
);

  localparam int ID_WIDTH = $clog2(CHANNEL_COUNT);

  arb_states                state_q, state_d;
  logic [ID_WIDTH-1:0]      last_grant_q, last_grant_d;
  logic                     out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0]    out_data_q, out_data_d;
  logic [ID_WIDTH-1:0]      out_channel_q, out_channel_d;
  logic [CHANNEL_COUNT-1:0] ch_ack_q, ch_ack_d;

  logic [CHANNEL_COUNT-1:0] eligible;
  logic                     pick_found;
  logic [ID_WIDTH-1:0]      pick_idx;
  logic [DATA_WIDTH-1:0]    ch_word [CHANNEL_COUNT];

  for (genvar gi = 0; gi < CHANNEL_COUNT; gi++) begin : g_unpack
    assign ch_word[gi] = bus.ch_data[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // A disabled channel's valid is simply invisible to the picker.
  assign eligible = bus.ch_valid & bus.enable_channels;

  tdc_rr_picker #(
    .CHANNEL_COUNT (CHANNEL_COUNT),
    .ID_WIDTH      (ID_WIDTH)
  ) u_picker (
    .eligible   (eligible),
    .last_grant (last_grant_q),
    .found      (pick_found),
    .idx        (pick_idx)
  );

`ifdef TDCARB_TIMEOUT_EN
  localparam int                  TIMER_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0]  TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  logic [TIMER_W-1:0] timer_q, timer_d;
  logic               timeout_err_q, timeout_err_d;
`endif

  always_comb begin
    state_d       = state_q;
    last_grant_d  = last_grant_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_channel_d = out_channel_q;
    ch_ack_d      = '0;
`ifdef TDCARB_TIMEOUT_EN
    timer_d       = timer_q;
    timeout_err_d = 1'b0;
`endif

    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          out_data_d         = ch_word[pick_idx];
          out_channel_d      = pick_idx;
          out_valid_d        = 1'b1;
          ch_ack_d[pick_idx] = 1'b1;
          state_d            = ARB_SEND;
`ifdef TDCARB_TIMEOUT_EN
          timer_d            = '0;
`endif
        end
      end
      ARB_SEND: begin
        // A ready arriving on the limit cycle still completes the transfer.
        if (bus.out_ready) begin
          out_valid_d  = 1'b0;
          last_grant_d = out_channel_q;
          state_d      = ARB_IDLE;
        end
`ifdef TDCARB_TIMEOUT_EN
        else if (timer_q == TIMER_LAST) begin
          out_valid_d   = 1'b0;
          last_grant_d  = out_channel_q;
          timeout_err_d = 1'b1;
          state_d       = ARB_IDLE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
`endif
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ARB_IDLE;
      last_grant_q  <= ID_WIDTH'(CHANNEL_COUNT - 1);
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_channel_q <= '0;
      ch_ack_q      <= '0;
    end else begin
      state_q       <= state_d;
      last_grant_q  <= last_grant_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_channel_q <= out_channel_d;
      ch_ack_q      <= ch_ack_d;
    end
  end

`ifdef TDCARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_q       <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      timer_q       <= timer_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign bus.timeout_err = timeout_err_q;
`else
  assign bus.timeout_err = 1'b0;
`endif

  assign bus.ch_ack      = ch_ack_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_data    = out_data_q;
  assign bus.out_channel = out_channel_q;
  assign bus.busy        = (state_q == ARB_SEND);

endmodule

// File: tb/tb_tdc_readout_arbiter.sv
// Bench for tdc_readout_arbiter with 4 channels: directed scenarios plus a
// transaction-level model checked every cycle. TDCARB_TIMEOUT_EN adds the timeout case.
module tb_tdc_readout_arbiter;
  import TDCArbPackage::*;

  localparam int N   = 4;
  localparam int DW  = 16;
`ifdef TDCARB_TIMEOUT_EN
  localparam int TB_TIMEOUT   = 8;
  localparam int STALL_CYCLES = 5;
`else
  localparam int TB_TIMEOUT   = 255;
  localparam int STALL_CYCLES = 10;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  tdc_readout_arbiter_if #(.CHANNEL_COUNT(N), .DATA_WIDTH(DW)) bus ();

  tdc_readout_arbiter #(
    .CHANNEL_COUNT  (N),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TB_TIMEOUT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- channel emulation (driven only by the stimulus process)
  int              rem  [N];
  logic [DW-1:0]   word [N];

  task automatic apply_channels();
    for (int i = 0; i < N; i++) begin
      bus.ch_valid[i]          = (rem[i] != 0);
      bus.ch_data[i*DW +: DW]  = word[i];
    end
  endtask

  task automatic load(input int ch, input int n, input logic [DW-1:0] w);
    rem[ch]  = n;
    word[ch] = w;
    apply_channels();
  endtask

  // Each cycle: after the edge, a channel that saw its ack presents its next word.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
      for (int i = 0; i < N; i++) begin
        if (bus.ch_ack[i] && rem[i] > 0) begin
          rem[i]  = rem[i] - 1;
          word[i] = word[i] + 1'b1;
        end
      end
      apply_channels();
      @(negedge clk);
    end
  endtask

  // ---------------- model: one word in flight at most, rotating priority
  int            cyc = 0;
  bit            m_busy = 0;
  bit            m_rst  = 1;
  int            m_ch   = 0;
  logic [DW-1:0] m_data = '0;
  int            m_last = N - 1;
  int            m_stall = 0;
  logic [N-1:0]  s_elig;
  bit            s_ready;
  logic [N-1:0]  e_ack;
  bit            e_terr;

  int            g_ch   [$];
  int            g_cyc  [$];
  logic [DW-1:0] g_data [$];
  int            busy_cnt = 0;
  int            terr_cnt = 0;
  int            terr_cyc = -1;

  function automatic int gch(input int k);
    return (k < g_ch.size()) ? g_ch[k] : -1;
  endfunction
  function automatic int gcyc(input int k);
    return (k < g_cyc.size()) ? g_cyc[k] : -1;
  endfunction
  function automatic logic [31:0] gdata(input int k);
    return (k < g_data.size()) ? 32'(g_data[k]) : 32'hDEAD_BEEF;
  endfunction

  always begin
    @(posedge clk);
    cyc++;
    s_elig  = bus.ch_valid & bus.enable_channels;
    s_ready = bus.out_ready;
    e_ack   = '0;
    e_terr  = 1'b0;
    if (!reset_n) begin
      m_busy  = 1'b0;
      m_last  = N - 1;
      m_stall = 0;
      m_rst   = 1'b1;
    end else begin
      m_rst = 1'b0;
      if (m_busy) begin
        if (s_ready) begin
          m_busy = 1'b0;
          m_last = m_ch;
        end else begin
          m_stall++;
`ifdef TDCARB_TIMEOUT_EN
          if (m_stall == TB_TIMEOUT) begin
            m_busy = 1'b0;
            m_last = m_ch;
            e_terr = 1'b1;
          end
`endif
        end
      end else begin
        for (int k = 1; k <= N; k++) begin
          int c;
          c = (m_last + k) % N;
          if (!m_busy && s_elig[c]) begin
            m_busy   = 1'b1;
            m_ch     = c;
            m_data   = bus.ch_data[c*DW +: DW];
            m_stall  = 0;
            e_ack[c] = 1'b1;
          end
        end
      end
    end
    #1;
    check("out_valid", 32'(bus.out_valid), 32'(m_busy));
    check("busy", 32'(bus.busy), 32'(m_busy));
    check("ch_ack", 32'(bus.ch_ack), 32'(e_ack));
    check("timeout_err", 32'(bus.timeout_err), 32'(e_terr));
    if (m_rst) begin
      check("rst_out_data", 32'(bus.out_data), 32'h0);
      check("rst_out_channel", 32'(bus.out_channel), 32'h0);
    end else if (m_busy) begin
      check("out_data", 32'(bus.out_data), 32'(m_data));
      check("out_channel", 32'(bus.out_channel), 32'(m_ch));
    end
    if (bus.ch_ack != '0) begin
      for (int i = 0; i < N; i++) begin
        if (bus.ch_ack[i]) g_ch.push_back(i);
      end
      g_cyc.push_back(cyc);
      g_data.push_back(bus.out_data);
    end
    if (bus.busy) busy_cnt++;
    if (bus.timeout_err) begin
      terr_cnt++;
      terr_cyc = cyc;
    end
  end

  // ---------------- directed stimulus
  int b, lc, bc, tc;

  initial begin
    for (int i = 0; i < N; i++) begin
      rem[i]  = 0;
      word[i] = '0;
    end
    bus.enable_channels = '0;
    bus.out_ready       = 1'b0;
    apply_channels();

    check("fn_wrap", rr_next_index(64'b0110, 3, 4), 32'd1);
    check("fn_none", rr_next_index(64'b0, 1, 4), 32'hFFFF_FFFF);
    check("fn_single", rr_next_index(64'b0001, 0, 4), 32'd0);

    repeat (3) @(negedge clk);
    check("reset_valid", 32'(bus.out_valid), 32'h0);
    check("reset_ack", 32'(bus.ch_ack), 32'h0);
    check("reset_busy", 32'(bus.busy), 32'h0);
    check("reset_data", 32'(bus.out_data), 32'h0);
    check("reset_chan", 32'(bus.out_channel), 32'h0);
    reset_n = 1'b1;

    // Full rotation with all channels holding two words each.
    bus.enable_channels = 4'hF;
    bus.out_ready       = 1'b1;
    b  = g_ch.size();
    lc = cyc;
    for (int i = 0; i < N; i++) load(i, 2, DW'((i << 12) + 1));
    step(18);
    check("rot_count", 32'(g_ch.size() - b), 32'd8);
    check("rot_g0", gch(b + 0), 32'd0);
    check("rot_g1", gch(b + 1), 32'd1);
    check("rot_g2", gch(b + 2), 32'd2);
    check("rot_g3", gch(b + 3), 32'd3);
    check("rot_g4", gch(b + 4), 32'd0);
    check("rot_latency", gcyc(b), 32'(lc + 1));
    for (int k = 0; k < 4; k++) check("rot_spacing", gcyc(b + k + 1) - gcyc(b + k), 32'd2);
    check("rot_data2", gdata(b + 2), 32'h2001);
    check("rot_data4", gdata(b + 4), 32'h0002);

    // Single word on channel 0.
    b  = g_ch.size();
    bc = busy_cnt;
    lc = cyc;
    load(0, 1, 16'h1234);
    step(4);
    check("single_count", 32'(g_ch.size() - b), 32'd1);
    check("single_chan", gch(b), 32'd0);
    check("single_data", gdata(b), 32'h1234);
    check("single_latency", gcyc(b), 32'(lc + 1));
    check("single_busy_cycles", 32'(busy_cnt - bc), 32'd1);

    // Disabled channel 1 waits until its enable bit is set.
    bus.enable_channels = 4'b0100;
    b = g_ch.size();
    load(1, 1, 16'hA1A1);
    load(2, 1, 16'hB2B2);
    step(8);
    check("mask_count", 32'(g_ch.size() - b), 32'd1);
    check("mask_chan", gch(b), 32'd2);
    bus.enable_channels = 4'b0110;
    step(4);
    check("unmask_count", 32'(g_ch.size() - b), 32'd2);
    check("unmask_chan", gch(b + 1), 32'd1);
    check("unmask_data", gdata(b + 1), 32'hA1A1);

    // Stall channel 3 in SEND, then release; next search starts at channel 0.
    bus.enable_channels = 4'hF;
    bus.out_ready       = 1'b0;
    b = g_ch.size();
    load(3, 1, 16'hC3C3);
    step(1);
    for (int k = 0; k < STALL_CYCLES; k++) begin
      check("stall_valid", 32'(bus.out_valid), 32'h1);
      check("stall_chan", 32'(bus.out_channel), 32'd3);
      check("stall_data", 32'(bus.out_data), 32'hC3C3);
      step(1);
    end
    bus.out_ready = 1'b1;
    step(1);
    check("stall_released", 32'(bus.out_valid), 32'h0);
    check("stall_count", 32'(g_ch.size() - b), 32'd1);
    load(0, 1, 16'h0D0D);
    load(2, 1, 16'h2E2E);
    step(6);
    check("after_stall_g0", gch(b + 1), 32'd0);
    check("after_stall_g1", gch(b + 2), 32'd2);

    // Asynchronous reset while a word waits in SEND.
    bus.out_ready = 1'b0;
    load(3, 1, 16'h3535);
    step(3);
    check("pre_reset_busy", 32'(bus.busy), 32'h1);
    @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    check("async_valid", 32'(bus.out_valid), 32'h0);
    check("async_busy", 32'(bus.busy), 32'h0);
    check("async_ack", 32'(bus.ch_ack), 32'h0);
    check("async_data", 32'(bus.out_data), 32'h0);
    check("async_chan", 32'(bus.out_channel), 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n       = 1'b1;
    bus.out_ready = 1'b1;
    b = g_ch.size();
    load(0, 1, 16'h0A0A);
    load(3, 1, 16'h3B3B);
    step(6);
    check("post_reset_count", 32'(g_ch.size() - b), 32'd2);
    check("post_reset_first", gch(b), 32'd0);
    check("post_reset_second", gch(b + 1), 32'd3);
    check("post_reset_data", gdata(b), 32'h0A0A);

`ifdef TDCARB_TIMEOUT_EN
    // Word dropped after TB_TIMEOUT stalled SEND cycles; next channel granted.
    bus.out_ready = 1'b0;
    b  = g_ch.size();
    tc = terr_cnt;
    load(1, 1, 16'h5151);
    load(2, 1, 16'h6262);
    step(13);
    check("to_pulses", 32'(terr_cnt - tc), 32'd1);
    check("to_first", gch(b), 32'd1);
    check("to_delay", terr_cyc - gcyc(b), 32'd8);
    check("to_next_chan", gch(b + 1), 32'd2);
    check("to_next_cycle", gcyc(b + 1), 32'(terr_cyc + 1));
    bus.out_ready = 1'b1;
    step(3);
`endif

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1);
  end

endmodule
